// File: rtl/approx_err_monitor.sv
// Error-metric monitor for an approximate adder: compares exact and approximate sums over a
// programmed window and accumulates sample count, error count, error-distance sum and maximum.
module approx_err_monitor #(
  parameter int DATA_W = 5,
  parameter int CNT_W  = 16,
  parameter int SUM_W  = CNT_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] exact_y,
  input  logic [DATA_W-1:0] approx_y,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]  sum_ed,
  output logic [DATA_W-1:0] max_ed
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [CNT_W-1:0]  sample;
    logic [CNT_W-1:0]  err;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] max;
  } stats_t;

  state_t           state, state_nxt;
  stats_t           st, st_nxt;
  logic [CNT_W-1:0] target, target_nxt;
  logic [DATA_W-1:0] ed;
  logic             hs;
  logic             run_q, done_q;

  // Larger minus smaller keeps the distance unsigned without wrap.
  assign ed = (exact_y >= approx_y) ? (exact_y - approx_y) : (approx_y - exact_y);
  assign hs = in_valid && run_q;

  always_comb begin
    state_nxt  = state;
    st_nxt     = st;
    target_nxt = target;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          st_nxt     = '0;
          target_nxt = num_samples;
          state_nxt  = (num_samples != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (hs) begin
          st_nxt.sample = st.sample + CNT_W'(1);
          st_nxt.err    = st.err + CNT_W'(ed != '0);
          st_nxt.sum    = st.sum + SUM_W'(ed);
          st_nxt.max    = (ed > st.max) ? ed : st.max;
          if (st_nxt.sample == target) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are flopped from the next state so in_ready never sees in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      st     <= '0;
      target <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      st     <= st_nxt;
      target <= target_nxt;
      run_q  <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
    end
  end

  assign in_ready   = run_q;
  assign busy       = run_q;
  assign done       = done_q;
  assign sample_cnt = st.sample;
  assign err_cnt    = st.err;
  assign sum_ed     = st.sum;
  assign max_ed     = st.max;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench: the driver pushes window results computed from the sample list, and a
// negedge monitor pops and checks them whenever done rises.
module tb_approx_err_monitor;
  localparam int DATA_W = 5;
  localparam int CNT_W  = 16;
  localparam int SUM_W  = CNT_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_samples = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] exact_y = '0;
  logic [DATA_W-1:0] approx_y = '0;
  logic              busy, done;
  logic [CNT_W-1:0]  sample_cnt, err_cnt;
  logic [SUM_W-1:0]  sum_ed;
  logic [DATA_W-1:0] max_ed;

  approx_err_monitor #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .exact_y(exact_y), .approx_y(approx_y),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint cnt, err, sum, mx, dcyc;
    string  name;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   last;
  int     we[$], wa[$];
  longint cyc = 0;
  int     n_cmp = 0, n_bad = 0;
  logic   done_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: window statistics straight from the definition of error distance.
  function automatic exp_t model(input string name, input longint dcyc);
    exp_t r;
    r.cnt = we.size(); r.err = 0; r.sum = 0; r.mx = 0; r.dcyc = dcyc; r.name = name;
    foreach (we[i]) begin
      int d;
      d = we[i] - wa[i];
      if (d < 0) d = -d;
      if (d != 0) r.err++;
      r.sum += d;
      if (d > r.mx) r.mx = d;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (done && !done_d) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".sample_cnt"}, sample_cnt, e.cnt);
        chk({e.name, ".err_cnt"}, err_cnt, e.err);
        chk({e.name, ".sum_ed"}, sum_ed, e.sum);
        chk({e.name, ".max_ed"}, max_ed, e.mx);
        chk({e.name, ".done_latency"}, cyc, e.dcyc);
        chk({e.name, ".in_ready_at_done"}, in_ready, 0);
        last = e;
      end
    end else if (done && done_d) begin
      chk({last.name, ".frozen_sample_cnt"}, sample_cnt, last.cnt);
      chk({last.name, ".frozen_sum_ed"}, sum_ed, last.sum);
    end
    done_d = done;
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic do_start(input int n, output longint c);
    start = 1'b1; num_samples = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0; num_samples = CNT_W'($urandom);
    c = cyc;
  endtask

  task automatic send(input int e, input int a, input int gap);
    int k;
    repeat (gap) begin
      in_valid = 1'b0; exact_y = DATA_W'($urandom); approx_y = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; exact_y = DATA_W'(e); approx_y = DATA_W'(a);
    k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    we.push_back(e); wa.push_back(a);
  endtask

  // Called right after the final handshake of a window.
  task automatic close_window(input string name);
    exp_q.push_back(model(name, cyc));
    we.delete(); wa.delete();
  endtask

  task automatic rand_window(input string name, input int n);
    longint c;
    do_start(n, c);
    for (int i = 0; i < n; i++) begin
      int e, a;
      e = $urandom_range(0, 31);
      a = ($urandom_range(0, 1) == 1) ? e : $urandom_range(0, 31);
      send(e, a, $urandom_range(0, 2));
    end
    close_window(name);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (exp_q.size() != 0) chk("done_wait_timeout", exp_q.size(), 0);
  endtask

  task automatic zero_window(input string name);
    longint c;
    do_start(0, c);
    we.delete(); wa.delete();
    exp_q.push_back(model(name, c));
    chk({name, ".in_ready"}, in_ready, 0);
    repeat (2) begin @(posedge clk); #1; chk({name, ".in_ready_hold"}, in_ready, 0); end
  endtask

  initial begin
    longint c;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 0); chk("rst.busy", busy, 0); chk("rst.done", done, 0);
    chk("rst.sample_cnt", sample_cnt, 0); chk("rst.sum_ed", sum_ed, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    zero_window("zero");
    drain();

    // Exact window: no errors.
    do_start(8, c);
    chk("exact.in_ready_after_start", in_ready, 1);
    for (int i = 0; i < 8; i++) send(i, i, 0);
    close_window("exact");
    drain();

    do_start(4, c);
    send(20, 16, 0); send(3, 7, 0); send(31, 0, 0); send(9, 9, 0);
    close_window("mixed");
    drain();

    // Valid pattern 1,0,0,1,0,1.
    do_start(3, c);
    send(5, 4, 0); send(2, 2, 2); send(0, 6, 1);
    close_window("gaps");
    drain();

    // start while running must not retarget or clear.
    do_start(5, c);
    send(12, 3, 0); send(7, 7, 0);
    start = 1'b1; num_samples = 1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_run.busy", busy, 1);
    chk("start_in_run.sample_cnt", sample_cnt, 2);
    send(1, 30, 0); send(16, 17, 1); send(0, 0, 0);
    close_window("start_in_run");
    drain();

    // In DONE, in_valid is ignored; the monitor checks freeze each cycle.
    repeat (3) begin
      in_valid = 1'b1; exact_y = DATA_W'($urandom); approx_y = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    do_start(2, c);
    chk("restart.sample_cnt_cleared", sample_cnt, 0);
    chk("restart.sum_ed_cleared", sum_ed, 0);
    chk("restart.max_ed_cleared", max_ed, 0);
    chk("restart.done_low", done, 0);
    send(25, 10, 0); send(4, 4, 1);
    close_window("restart");
    drain();

    for (int w = 0; w < 10; w++) begin
      rand_window($sformatf("rand%0d", w), $urandom_range(1, 20));
      drain();
    end

    // Reset mid-window discards the partial window.
    do_start(10, c);
    send(3, 9, 0); send(8, 8, 0); send(31, 30, 0);
    rst_n = 1'b0;
    #1;
    we.delete(); wa.delete();
    chk("midrst.in_ready", in_ready, 0); chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0); chk("midrst.sample_cnt", sample_cnt, 0);
    chk("midrst.err_cnt", err_cnt, 0); chk("midrst.sum_ed", sum_ed, 0);
    chk("midrst.max_ed", max_ed, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst.in_ready_after_release", in_ready, 0);
    chk("midrst.done_after_release", done, 0);

    rand_window("post_rst", 6);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/approx_err_monitor.md
Name: approx_err_monitor

Overview:
- Downstream consumer of the 4-bit adder stage. Receives the exact adder sum and a candidate approximate adder sum for the same operands, one pair per handshake.
- Accumulates error metrics over a programmed sample window: sample count, erroneous-sample count, sum of error distance, and max error distance.
- Results feed the approximate-adder characterisation flow (error rate = err_cnt/sample_cnt, MED = sum_ed/sample_cnt).

Parameters:
- DATA_W, 5, width of adder sum inputs (4-bit operands plus carry-out).
- CNT_W, 16, width of sample and error counters.
- SUM_W, CNT_W+DATA_W, width of error-distance accumulator; sized so it cannot overflow.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new window (honoured in IDLE and DONE only).
- num_samples  in  CNT_W  window length; sampled on an accepted start.
- in_valid  in  1  exact_y/approx_y pair valid.
- in_ready  out  1  monitor accepts a pair this cycle.
- exact_y  in  DATA_W  exact adder sum, unsigned.
- approx_y  in  DATA_W  approximate adder sum, unsigned.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; statistics final and stable.
- sample_cnt  out  CNT_W  accepted pairs in current window.
- err_cnt  out  CNT_W  accepted pairs with exact_y != approx_y.
- sum_ed  out  SUM_W  sum of |exact_y - approx_y|.
- max_ed  out  DATA_W  maximum |exact_y - approx_y|.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, busy, done = 0; all counters and accumulators = 0; latched target = 0. Release is synchronous to clk.
- FSM states: IDLE, RUN, DONE. in_ready = busy = (state==RUN), decoded from the state register with no combinational path from in_valid. All outputs are registered.
- IDLE or DONE, with start=1:
  - Clear sample_cnt, err_cnt, sum_ed and max_ed.
  - Latch num_samples as the target.
  - If num_samples != 0, next state is RUN; otherwise next state is DONE with zero statistics.
- IDLE, start=0: remain in IDLE. in_valid is ignored.
- RUN: a handshake occurs on a cycle with in_valid && in_ready.
  - Error distance: ed = |exact_y - approx_y|, computed as unsigned DATA_W using the larger operand minus the smaller (no wrap).
  - On a handshake: sample_cnt += 1; err_cnt += (ed != 0); sum_ed += ed; max_ed = max(max_ed, ed).
  - The updated values are visible the cycle after the handshake.
  - When the handshake makes sample_cnt equal to the target, next state is DONE, so done=1 and in_ready=0 on the following cycle.
  - start in RUN is ignored.
- DONE: done is held high and statistics are frozen until start or reset. in_valid is ignored.
- Latency: from the final handshake to done=1 is 1 cycle. From start to in_ready=1 is 1 cycle.
- Gaps in in_valid during RUN: no update and no timeout; the monitor waits indefinitely.
- Arithmetic limits: sum_ed cannot overflow, since max is (2^CNT_W-1)*(2^DATA_W-1) < 2^SUM_W. Counters cannot exceed the target, and the target is at most 2^CNT_W-1.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0; any partial window is discarded.

Test Plan:
- Reset mid-window: start with num_samples=10, complete 3 handshakes, pulse rst_n low -> all outputs 0 asynchronously, state IDLE, in_ready=0 after release.
- Exact window: num_samples=8, 8 pairs with approx_y==exact_y (values 0..7) -> done=1 one cycle after the 8th handshake, sample_cnt=8, err_cnt=0, sum_ed=0, max_ed=0, in_ready=0.
- Mixed errors: num_samples=4, pairs (20,16), (3,7), (31,0), (9,9) -> sample_cnt=4, err_cnt=3, sum_ed=39, max_ed=31; the (3,7) pair gives ed=4 with no wrap.
- Valid gaps: num_samples=3, in_valid pattern 1,0,0,1,0,1 with pairs (5,4), (2,2), (0,6) -> counts only the 3 handshakes: err_cnt=2, sum_ed=7, max_ed=6; done is asserted the cycle after the 6th stimulus cycle.
- Zero window: start with num_samples=0 -> done=1 next cycle, in_ready never high, all statistics 0.
- Start handling:
  - Pulse start during RUN -> ignored, and the window completes with the original target.
  - Pulse start in DONE with num_samples=2 -> statistics cleared next cycle, RUN, new results reflect only the 2 new pairs.
